// File: rtl/round_sequencer.sv
// Two-player dodge-game round controller: idle -> countdown -> play -> game-over, with BCD survival scores.
// Optional PLAY length limit is compiled in with `define ROUND_TIMEOUT_EN (draw when the limit expires).
module round_sequencer #(
  parameter int CD_START    = 3,
  parameter int HOLD_TICKS  = 5,
  parameter int ROUND_TICKS = 60
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       coll1,
  input  logic       coll2,
  output logic       play_rst,
  output logic       scroll_en,
  output logic [1:0] state,
  output logic [3:0] cd_digit,
  output logic [7:0] score1,
  output logic [7:0] score2,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_t;

  if (CD_START < 1 || CD_START > 9 || HOLD_TICKS < 1 || HOLD_TICKS > 15 ||
      ROUND_TICKS < 1 || ROUND_TICKS > 255) begin : g_bad_param
    $error("round_sequencer: parameter out of range");
  end

  state_t     state_q, state_d;
  logic [3:0] cd_q, cd_d;
  logic [7:0] score1_q, score1_d;
  logic [7:0] score2_q, score2_d;
  logic [1:0] winner_q, winner_d;
  logic [3:0] hold_q, hold_d;
  logic       play_rst_q, play_rst_d;
  logic       scroll_q, scroll_d;
`ifdef ROUND_TIMEOUT_EN
  logic [7:0] play_cnt_q, play_cnt_d;
`endif

  // Saturating two-digit BCD increment; 99 sticks.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)
      return v;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_comb begin
    state_d    = state_q;
    cd_d       = cd_q;
    score1_d   = score1_q;
    score2_d   = score2_q;
    winner_d   = winner_q;
    hold_d     = hold_q;
    play_rst_d = 1'b0;
`ifdef ROUND_TIMEOUT_EN
    play_cnt_d = play_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = COUNT;
          play_rst_d = 1'b1;
          score1_d   = 8'h00;
          score2_d   = 8'h00;
          winner_d   = 2'b00;
          cd_d       = 4'(CD_START);
        end
      end
      COUNT: begin
        if (tick) begin
          if (cd_q == 4'd1) begin
            state_d = PLAY;
            cd_d    = 4'd0;
`ifdef ROUND_TIMEOUT_EN
            play_cnt_d = 8'd0;
`endif
          end else begin
            cd_d = cd_q - 4'd1;
          end
        end
      end
      PLAY: begin
        // A collision outranks a simultaneous tick: the score freezes before it.
        if (coll1 || coll2) begin
          state_d  = OVER;
          winner_d = {coll1, coll2};
          hold_d   = 4'd0;
        end else if (tick) begin
          score1_d = bcd_inc(score1_q);
          score2_d = bcd_inc(score2_q);
`ifdef ROUND_TIMEOUT_EN
          play_cnt_d = play_cnt_q + 8'd1;
          if (play_cnt_q + 8'd1 == 8'(ROUND_TICKS)) begin
            state_d  = OVER;
            winner_d = 2'b11;
            hold_d   = 4'd0;
          end
`endif
        end
      end
      OVER: begin
        if (tick) begin
          if (hold_q == 4'(HOLD_TICKS - 1)) begin
            state_d = IDLE;
            hold_d  = 4'd0;
          end else begin
            hold_d = hold_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    scroll_d = (state_d == PLAY);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cd_q       <= 4'd0;
      score1_q   <= 8'h00;
      score2_q   <= 8'h00;
      winner_q   <= 2'b00;
      hold_q     <= 4'd0;
      play_rst_q <= 1'b0;
      scroll_q   <= 1'b0;
`ifdef ROUND_TIMEOUT_EN
      play_cnt_q <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      cd_q       <= cd_d;
      score1_q   <= score1_d;
      score2_q   <= score2_d;
      winner_q   <= winner_d;
      hold_q     <= hold_d;
      play_rst_q <= play_rst_d;
      scroll_q   <= scroll_d;
`ifdef ROUND_TIMEOUT_EN
      play_cnt_q <= play_cnt_d;
`endif
    end
  end

  assign state     = state_q;
  assign cd_digit  = cd_q;
  assign score1    = score1_q;
  assign score2    = score2_q;
  assign winner    = winner_q;
  assign play_rst  = play_rst_q;
  assign scroll_en = scroll_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer: expected output snapshots are queued with each step and checked after the edge.
module tb_round_sequencer;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       tick, start, coll1, coll2;
  logic       play_rst, scroll_en;
  logic [1:0] state;
  logic [3:0] cd_digit;
  logic [7:0] score1, score2;
  logic [1:0] winner;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [25:0] val;
  } exp_t;
  exp_t sb[$];

  round_sequencer #(
    .CD_START   (3),
    .HOLD_TICKS (5),
    .ROUND_TICKS(10)
  ) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .tick     (tick),
    .start    (start),
    .coll1    (coll1),
    .coll2    (coll2),
    .play_rst (play_rst),
    .scroll_en(scroll_en),
    .state    (state),
    .cd_digit (cd_digit),
    .score1   (score1),
    .score2   (score2),
    .winner   (winner)
  );

  always #5 clk_in = ~clk_in;

  // Snapshot layout: state, cd_digit, score1, score2, winner, play_rst, scroll_en.
  function automatic logic [25:0] snap(input logic [1:0] st, input logic [3:0] cd,
                                       input logic [7:0] s1, input logic [7:0] s2,
                                       input logic [1:0] w, input logic pr, input logic se);
    return {st, cd, s1, s2, w, pr, se};
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  task automatic push(input string tag, input logic [25:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [25:0] obs;
    obs = snap(state, cd_digit, score1, score2, winner, play_rst, scroll_en);
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty: observed=%h required=<queued entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s: observed=%h required=%h", e.tag, obs, e.val);
      end
    end
  endtask

  // Inputs change on the falling edge; outputs are checked on the next falling edge.
  task automatic cyc(input logic t, input logic s, input logic c1, input logic c2);
    tick = t; start = s; coll1 = c1; coll2 = c2;
    @(posedge clk_in);
    @(negedge clk_in);
    tick = 1'b0; start = 1'b0; coll1 = 1'b0; coll2 = 1'b0;
  endtask

  task automatic step(input string tag, input logic t, input logic s, input logic c1,
                      input logic c2, input logic [25:0] v);
    push(tag, v);
    cyc(t, s, c1, c2);
    check();
  endtask

  initial begin
    tick = 1'b0; start = 1'b0; coll1 = 1'b0; coll2 = 1'b0;
    reset = 1'b1;
    #12;
    push("reset_values", snap(2'd0, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0));
    check();
    @(negedge clk_in);
    reset = 1'b0;

    // Round 1: start, countdown, 12 ticks of play, player-1 collision.
    step("idle_tick_ignored", 1, 0, 0, 0, snap(2'd0, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0));
    step("start_to_count",    0, 1, 0, 0, snap(2'd1, 4'd3, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0));
    step("play_rst_one_cyc",  0, 0, 0, 0, snap(2'd1, 4'd3, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0));
    step("count_2",           1, 0, 1, 1, snap(2'd1, 4'd2, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0));
    step("count_1",           1, 0, 0, 0, snap(2'd1, 4'd1, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0));
    step("count_to_play",     1, 0, 0, 0, snap(2'd2, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1));
    step("play_no_tick",      0, 0, 0, 0, snap(2'd2, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1));
    for (int i = 1; i <= 12; i++)
      step($sformatf("play_tick_%0d", i), 1, 0, 0, 0,
           snap(2'd2, 4'd0, to_bcd(i), to_bcd(i), 2'b00, 1'b0, 1'b1));
    step("coll1_over",        0, 0, 1, 0, snap(2'd3, 4'd0, 8'h12, 8'h12, 2'b10, 1'b0, 1'b0));
    step("over_tick1_frozen", 1, 0, 1, 0, snap(2'd3, 4'd0, 8'h12, 8'h12, 2'b10, 1'b0, 1'b0));
    step("over_start_ignore", 0, 1, 0, 0, snap(2'd3, 4'd0, 8'h12, 8'h12, 2'b10, 1'b0, 1'b0));
    for (int i = 2; i <= 4; i++)
      step($sformatf("over_hold_%0d", i), 1, 0, 0, 1,
           snap(2'd3, 4'd0, 8'h12, 8'h12, 2'b10, 1'b0, 1'b0));
    step("over_to_idle",      1, 0, 0, 0, snap(2'd0, 4'd0, 8'h12, 8'h12, 2'b10, 1'b0, 1'b0));
    step("idle_persist",      1, 0, 1, 1, snap(2'd0, 4'd0, 8'h12, 8'h12, 2'b10, 1'b0, 1'b0));

    // Round 2: start+tick together, then a simultaneous double collision on a tick.
    step("start_with_tick",   1, 1, 0, 0, snap(2'd1, 4'd3, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0));
    repeat (2) cyc(1, 0, 0, 0);
    step("r2_play",           1, 0, 0, 0, snap(2'd2, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1));
    repeat (2) cyc(1, 0, 0, 0);
    step("r2_score_02",       0, 0, 0, 0, snap(2'd2, 4'd0, 8'h02, 8'h02, 2'b00, 1'b0, 1'b1));
    step("draw_on_tick",      1, 0, 1, 1, snap(2'd3, 4'd0, 8'h02, 8'h02, 2'b11, 1'b0, 1'b0));
    repeat (4) cyc(1, 0, 0, 0);
    step("r2_idle",           1, 0, 0, 0, snap(2'd0, 4'd0, 8'h02, 8'h02, 2'b11, 1'b0, 1'b0));

`ifndef ROUND_TIMEOUT_EN
    // Round 3: long play saturates both scores, player-2 collision ends it.
    step("r3_start",          0, 1, 0, 0, snap(2'd1, 4'd3, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0));
    repeat (3) cyc(1, 0, 0, 0);
    for (int i = 1; i <= 105; i++) begin
      if (i == 9 || i == 10 || i == 99 || i >= 100)
        step($sformatf("sat_tick_%0d", i), 1, 0, 0, 0,
             snap(2'd2, 4'd0, to_bcd(i > 99 ? 99 : i), to_bcd(i > 99 ? 99 : i), 2'b00, 1'b0, 1'b1));
      else
        cyc(1, 0, 0, 0);
    end
    step("coll2_over",        0, 0, 0, 1, snap(2'd3, 4'd0, 8'h99, 8'h99, 2'b01, 1'b0, 1'b0));
    repeat (4) cyc(1, 0, 0, 0);
    step("sat_over_to_idle",  1, 0, 0, 0, snap(2'd0, 4'd0, 8'h99, 8'h99, 2'b01, 1'b0, 1'b0));
`endif

    // Reset asserted mid-countdown takes effect without a clock edge.
    step("r4_start",          0, 1, 0, 0, snap(2'd1, 4'd3, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0));
    step("r4_cd_2",           1, 0, 0, 0, snap(2'd1, 4'd2, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0));
    reset = 1'b1;
    #1;
    push("async_reset", snap(2'd0, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0));
    check();
    @(negedge clk_in);
    reset = 1'b0;
    step("after_reset_idle",  1, 0, 0, 0, snap(2'd0, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0));

`ifdef ROUND_TIMEOUT_EN
    // Round limit of 10 ticks ends the round as a draw.
    step("to_start",          0, 1, 0, 0, snap(2'd1, 4'd3, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0));
    repeat (3) cyc(1, 0, 0, 0);
    repeat (8) cyc(1, 0, 0, 0);
    step("to_tick9",          1, 0, 0, 0, snap(2'd2, 4'd0, 8'h09, 8'h09, 2'b00, 1'b0, 1'b1));
    step("timeout_draw",      1, 0, 0, 0, snap(2'd3, 4'd0, 8'h10, 8'h10, 2'b11, 1'b0, 1'b0));
`endif

    if (sb.size() != 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_leftover: observed=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
